// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core constants, ALU opcodes and the ID/EX record.
// Provides widths, ALU operation codes, the id_ex_t register layout and a
// helper that models register-file write-through for operands captured into EX.
package core_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int OPCODE_LENGTH = 4;
  localparam int REG_ADDR_W    = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_XOR = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_NE  = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_LT  = 4'b1100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_GE  = 4'b1101;

  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     branch;
    logic                     alu_src;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [REG_ADDR_W-1:0]    rd;
    logic [REG_ADDR_W-1:0]    rs1;
    logic [REG_ADDR_W-1:0]    rs2;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
  } id_ex_t;

  // The register file does not write through, so a value being written back
  // on the same edge that ID reads it must be taken from the WB bus instead.
  function automatic logic [DATA_WIDTH-1:0] wb_bypass(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_reg_write,
    input logic [DATA_WIDTH-1:0] wb_result
  );
    if (wb_reg_write && (wb_rd == idx) && (idx != '0))
      return wb_result;
    return rf_data;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: forwarding select for one ALU operand.
// Ports: reg_idx/reg_data  - registered source index and value in EX
//        mem_*             - EX/MEM forward source (highest priority)
//        wb_*              - MEM/WB forward source
//        fwd_data          - selected operand value
// x0 is never forwarded.
module fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] reg_idx,
  input  logic [DW-1:0] reg_data,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic [DW-1:0] mem_result,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_reg_write,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] fwd_data
);

  logic nz;
  assign nz = (reg_idx != '0);

  always_comb begin
    fwd_data = reg_data;
    if (nz && mem_reg_write && (mem_rd == reg_idx))
      fwd_data = mem_result;
    else if (nz && wb_reg_write && (wb_rd == reg_idx))
      fwd_data = wb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and ALU operand select.
// Ports: clk/reset (sync, active-low), id_* decode outputs, mem_*/wb_*
//        forward sources, hold (freeze), flush (kill incoming instruction).
//        Outputs SrcA/SrcB/Operation to the ALU, registered ex_* fields,
//        ex_store_data (forwarded rs2) and hz_stall (load-use freeze request).
module ex_operand_stage #(
  parameter int DATA_WIDTH    = core_pkg::DATA_WIDTH,
  parameter int OPCODE_LENGTH = core_pkg::OPCODE_LENGTH,
  parameter int REG_ADDR_W    = core_pkg::REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_branch,
  input  logic [REG_ADDR_W-1:0]    mem_rd,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  input  logic                     hold,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     hz_stall
);

  import core_pkg::*;

  id_ex_t                ex_q;
  id_ex_t                cap;
  logic                  load_use;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  always_comb begin
    cap           = '0;
    cap.valid     = id_valid;
    cap.reg_write = id_reg_write & id_valid;
    cap.mem_read  = id_mem_read  & id_valid;
    cap.mem_write = id_mem_write & id_valid;
    cap.branch    = id_branch    & id_valid;
    cap.alu_src   = id_alu_src;
    cap.alu_op    = id_alu_op;
    cap.rd        = id_rd;
    cap.rs1       = id_rs1;
    cap.rs2       = id_rs2;
    cap.pc        = id_pc;
    cap.imm       = id_imm;
    cap.rs1_data  = wb_bypass(id_rs1, id_rs1_data, wb_rd, wb_reg_write, wb_result);
    cap.rs2_data  = wb_bypass(id_rs2, id_rs2_data, wb_rd, wb_reg_write, wb_result);
  end

  // A load in EX whose result is needed by ID cannot be forwarded in time;
  // one bubble lets the load reach MEM, after which normal forwarding covers it.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  assign hz_stall = load_use && !flush && !hold;

  always_ff @(posedge clk) begin
    if (!reset)
      ex_q <= '0;
    else if (!hold) begin
      if (flush || load_use)
        ex_q <= '0;
      else
        ex_q <= cap;
    end
  end

  fwd_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_W)) u_fwd_rs1 (
    .reg_idx       (ex_q.rs1),
    .reg_data      (ex_q.rs1_data),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_W)) u_fwd_rs2 (
    .reg_idx       (ex_q.rs2),
    .reg_data      (ex_q.rs2_data),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  assign SrcA          = fwd_rs1;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_rd         = ex_q.rd;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        hold, flush;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_imm, ex_store_data;
  logic        hz_stall;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .hold(hold), .flush(flush),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data),
    .hz_stall(hz_stall)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alu_src;
    logic [3:0]  op;
    logic        rw, mr, mw, br;
    logic [31:0] e_srca, e_srcb, e_store;
    logic        e_valid, e_rw;
  } vec_t;

  vec_t tbl[7];
  vec_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
    input logic alu_src, input logic [3:0] op,
    input logic rw, input logic mr, input logic mw, input logic br,
    input logic [31:0] e_srca, input logic [31:0] e_srcb, input logic [31:0] e_store,
    input logic e_valid, input logic e_rw);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.d1 = d1; v.d2 = d2; v.imm = imm; v.alu_src = alu_src; v.op = op;
    v.rw = rw; v.mr = mr; v.mw = mw; v.br = br;
    v.e_srca = e_srca; v.e_srcb = e_srcb; v.e_store = e_store;
    v.e_valid = e_valid; v.e_rw = e_rw;
    return v;
  endfunction

  function automatic logic [31:0] pc_of(input logic [4:0] rd);
    return 32'h0000_0400 + {25'd0, rd, 2'b00};
  endfunction

  task automatic put_id(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
    id_alu_src = v.alu_src; id_alu_op = v.op;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_branch = v.br;
    id_pc = pc_of(v.rd);
  endtask

  task automatic fwd_idle();
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; wb_result = 32'h0;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z, v, e;
    z = mk(0,0,0,0,0,0,0,0,4'h0,0,0,0,0,0,0,0,0,0);

    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    put_id(z); fwd_idle();

    // reset state
    edge_then_sample();
    edge_then_sample();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, Operation}, 32'd0);
    chk("rst_srca", SrcA, 32'd0);
    chk("rst_srcb", SrcB, 32'd0);
    chk("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
    chk("rst_hz", {31'd0, hz_stall}, 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // table-driven capture vectors, no forwarding active
    tbl[0] = mk(1, 1, 2, 3, 32'h100, 32'h200, 32'h4, 0, ALU_ADD, 1,0,0,0,
                32'h100, 32'h200, 32'h200, 1, 1);
    tbl[1] = mk(1, 4, 5, 6, 32'h300, 32'h77, 32'hFFFF_FFF0, 1, ALU_SUB, 1,0,0,0,
                32'h300, 32'hFFFF_FFF0, 32'h77, 1, 1);
    tbl[2] = mk(0, 7, 8, 9, 32'h12, 32'h34, 32'h0, 0, ALU_AND, 1,0,0,0,
                32'h12, 32'h34, 32'h34, 0, 0);
    tbl[3] = mk(1, 1, 2, 9, 32'h1000, 32'hDEAD, 32'h8, 1, ALU_ADD, 1,1,0,0,
                32'h1000, 32'h8, 32'hDEAD, 1, 1);
    tbl[4] = mk(1, 2, 3, 4, 32'hA5A5, 32'h5A5A, 32'h0, 0, ALU_XOR, 1,0,0,0,
                32'hA5A5, 32'h5A5A, 32'h5A5A, 1, 1);
    tbl[5] = mk(1, 0, 0, 5, 32'h0, 32'h0, 32'h10, 0, ALU_OR, 0,0,1,0,
                32'h0, 32'h0, 32'h0, 1, 0);
    tbl[6] = mk(1, 10, 11, 12, 32'h8000_0000, 32'h1, 32'h0, 0, ALU_LT, 1,0,0,0,
                32'h8000_0000, 32'h1, 32'h1, 1, 1);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      put_id(tbl[i]);
      sbq.push_back(tbl[i]);
      #1 chk("tbl_hz", {31'd0, hz_stall}, 32'd0);
      edge_then_sample();
      e = sbq.pop_front();
      chk("tbl_srca", SrcA, e.e_srca);
      chk("tbl_srcb", SrcB, e.e_srcb);
      chk("tbl_store", ex_store_data, e.e_store);
      chk("tbl_op", {28'd0, Operation}, {28'd0, e.op});
      chk("tbl_valid", {31'd0, ex_valid}, {31'd0, e.e_valid});
      chk("tbl_rw", {31'd0, ex_reg_write}, {31'd0, e.e_rw});
      chk("tbl_rd", {27'd0, ex_rd}, {27'd0, e.rd});
      chk("tbl_pc", ex_pc, pc_of(e.rd));
    end

    // MEM forward beats WB forward
    @(negedge clk);
    put_id(mk(1, 5, 6, 7, 32'h33, 32'h44, 0, 0, ALU_ADD, 1,0,0,0, 0,0,0,0,0));
    edge_then_sample();
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h22;
    #1 chk("memprio_srca", SrcA, 32'h11);
    mem_reg_write = 1'b0;
    #1 chk("wbfwd_srca", SrcA, 32'h22);
    wb_reg_write = 1'b0;
    #1 chk("nofwd_srca", SrcA, 32'h33);
    fwd_idle();

    // x0 is never forwarded
    @(negedge clk);
    put_id(mk(1, 0, 0, 4, 32'h0, 32'h0, 32'h55, 0, ALU_ADD, 1,0,0,0, 0,0,0,0,0));
    edge_then_sample();
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFFFF_FFFF;
    wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hFFFF_FFFF;
    #1 chk("x0_srcb", SrcB, 32'h0);
    chk("x0_srca", SrcA, 32'h0);
    chk("x0_store", ex_store_data, 32'h0);
    fwd_idle();

    // load-use: lw x7 then add x8,x7,x1
    @(negedge clk);
    put_id(mk(1, 2, 0, 7, 32'h0, 32'h0, 32'h4, 1, ALU_ADD, 1,1,0,0, 0,0,0,0,0));
    edge_then_sample();
    @(negedge clk);
    put_id(mk(1, 7, 1, 8, 32'h70, 32'h1, 32'h0, 0, ALU_ADD, 1,0,0,0, 0,0,0,0,0));
    #1 chk("lu_hz", {31'd0, hz_stall}, 32'd1);
    edge_then_sample();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_op", {28'd0, Operation}, 32'd0);
    chk("lu_hz_after", {31'd0, hz_stall}, 32'd0);
    edge_then_sample();
    chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cap_op", {28'd0, Operation}, {28'd0, ALU_ADD});
    chk("lu_cap_rd", {27'd0, ex_rd}, 32'd8);
    chk("lu_cap_srca", SrcA, 32'h70);

    // flush beats load-use
    @(negedge clk);
    put_id(mk(1, 2, 0, 7, 32'h0, 32'h0, 32'h4, 1, ALU_ADD, 1,1,0,0, 0,0,0,0,0));
    edge_then_sample();
    @(negedge clk);
    put_id(mk(1, 7, 1, 8, 32'h70, 32'h1, 32'h0, 0, ALU_SUB, 1,0,0,0, 0,0,0,0,0));
    flush = 1'b1;
    #1 chk("fl_lu_hz", {31'd0, hz_stall}, 32'd0);
    edge_then_sample();
    chk("fl_lu_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_lu_rw", {31'd0, ex_reg_write}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    edge_then_sample();
    chk("fl_lu_cap_op", {28'd0, Operation}, {28'd0, ALU_SUB});

    // WB bypass at capture
    @(negedge clk);
    put_id(mk(1, 3, 0, 2, 32'h5, 32'h0, 32'h0, 0, ALU_ADD, 1,0,0,0, 0,0,0,0,0));
    wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 32'h9;
    edge_then_sample();
    wb_reg_write = 1'b0; wb_result = 32'h0;
    #1 chk("wbcap_srca", SrcA, 32'h9);
    fwd_idle();

    // hold for 3 cycles with changing ID, then hold+flush, then flush
    @(negedge clk);
    put_id(mk(1, 4, 6, 10, 32'h10, 32'h20, 32'h0, 0, ALU_XOR, 1,0,0,0, 0,0,0,0,0));
    edge_then_sample();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hold = 1'b1;
      v = mk(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd11,
             $urandom, $urandom, $urandom, 1'($urandom), ALU_GE, 1,0,0,1, 0,0,0,0,0);
      put_id(v);
      edge_then_sample();
      chk("hold_srca", SrcA, 32'h10);
      chk("hold_op", {28'd0, Operation}, {28'd0, ALU_XOR});
      chk("hold_rd", {27'd0, ex_rd}, 32'd10);
    end
    @(negedge clk);
    hold = 1'b1; flush = 1'b1;
    edge_then_sample();
    chk("holdflush_valid", {31'd0, ex_valid}, 32'd1);
    chk("holdflush_rw", {31'd0, ex_reg_write}, 32'd1);
    @(negedge clk);
    hold = 1'b0; flush = 1'b1;
    edge_then_sample();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    @(negedge clk);
    flush = 1'b0;

    // reset mid-operation with a beq in EX (also overrides hold)
    put_id(mk(1, 1, 2, 0, 32'h5, 32'h5, 32'h20, 0, ALU_EQ, 0,0,0,1, 0,0,0,0,0));
    edge_then_sample();
    chk("beq_op", {28'd0, Operation}, {28'd0, ALU_EQ});
    chk("beq_branch", {31'd0, ex_branch}, 32'd1);
    @(negedge clk);
    reset = 1'b0; hold = 1'b1;
    edge_then_sample();
    chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_op", {28'd0, Operation}, 32'd0);
    chk("midrst_branch", {31'd0, ex_branch}, 32'd0);
    chk("midrst_srca", SrcA, 32'd0);
    chk("midrst_srcb", SrcB, 32'd0);
    chk("midrst_hz", {31'd0, hz_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1; hold = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
